// File: rtl/image_mem_writer.sv
// Packs a stream of pixels MSB-first into memory words and writes them to
// consecutive addresses from 0. A fill ends after the last address or after s_last.
module image_mem_writer #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16,
  parameter int PIX_WIDTH  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [PIX_WIDTH-1:0]  s_pixel,
  input  logic                  s_last,
  output logic                  wea,
  output logic [ADDR_WIDTH-1:0] addra,
  output logic [DATA_WIDTH-1:0] dina,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   words_written
);

  localparam int PPW   = DATA_WIDTH / PIX_WIDTH;
  localparam int CNT_W = (PPW > 1) ? $clog2(PPW) : 1;
  localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(PPW - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] pack_q, pack_d;
  logic [ADDR_WIDTH:0]   words_q, words_d;
  logic                  wea_q, wea_d;
  logic [ADDR_WIDTH-1:0] addra_q, addra_d;
  logic [DATA_WIDTH-1:0] dina_q, dina_d;
  logic [DATA_WIDTH-1:0] word_s;
  logic                  accept_s;

  assign accept_s      = s_valid && (state_q == FILL);
  assign s_ready       = (state_q == FILL);
  assign busy          = (state_q == FILL);
  assign done          = (state_q == DONE);
  assign wea           = wea_q;
  assign addra         = addra_q;
  assign dina          = dina_q;
  assign words_written = words_q;

  // Pack word including the incoming pixel; slot 0 is the most significant.
  always_comb begin
    word_s = pack_q;
    for (int i = 0; i < PPW; i++) begin
      word_s[DATA_WIDTH-1-i*PIX_WIDTH -: PIX_WIDTH] =
        (cnt_q == CNT_W'(i)) ? s_pixel : pack_q[DATA_WIDTH-1-i*PIX_WIDTH -: PIX_WIDTH];
    end
  end

  // Next-state, packing and write-issue logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    pack_d  = pack_q;
    words_d = words_q;
    wea_d   = 1'b0;
    addra_d = addra_q;
    dina_d  = dina_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = FILL;
          ptr_d   = '0;
          cnt_d   = '0;
          pack_d  = '0;
          words_d = '0;
        end else begin
          state_d = state_q;
        end
      end
      FILL: begin
        if (accept_s) begin
          if ((cnt_q == CNT_LAST) || s_last) begin
            // Word complete: issue the write and free the pack register at once.
            wea_d   = 1'b1;
            addra_d = ptr_q;
            dina_d  = word_s;
            pack_d  = '0;
            cnt_d   = '0;
            words_d = words_q + (ADDR_WIDTH+1)'(1);
            if ((ptr_q == LAST_ADDR) || s_last) begin
              state_d = DONE;
            end else begin
              state_d = FILL;
            end
            ptr_d = (ptr_q == LAST_ADDR) ? ptr_q : ptr_q + ADDR_WIDTH'(1);
          end else begin
            pack_d = word_s;
            cnt_d  = cnt_q + CNT_W'(1);
          end
        end else begin
          state_d = FILL;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      pack_q  <= '0;
      words_q <= '0;
      wea_q   <= 1'b0;
      addra_q <= '0;
      dina_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      pack_q  <= pack_d;
      words_q <= words_d;
      wea_q   <= wea_d;
      addra_q <= addra_d;
      dina_q  <= dina_d;
    end
  end

endmodule

// File: tb/tb_image_mem_writer.sv
// Directed self-checking bench for image_mem_writer with default parameters
// (16 one-bit pixels per 16-bit word, 16 addresses).
`timescale 1ns/1ps
module tb_image_mem_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [0:0]  s_pixel = 1'b0;
  logic        s_last = 1'b0;
  logic        wea;
  logic [3:0]  addra;
  logic [15:0] dina;
  logic        busy;
  logic        done;
  logic [4:0]  words_written;

  int checks = 0;
  int errors = 0;

  int          wr_n = 0;
  logic [3:0]  wr_addr [0:63];
  logic [15:0] wr_data [0:63];

  image_mem_writer dut (
    .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_ready(s_ready),
    .s_pixel(s_pixel), .s_last(s_last), .wea(wea), .addra(addra), .dina(dina),
    .busy(busy), .done(done), .words_written(words_written)
  );

  always #5 clk = ~clk;

  // Log every cycle with wea high, so a stretched pulse shows up as an extra write.
  always @(negedge clk) begin
    if (wea) begin
      if (wr_n < 64) begin
        wr_addr[wr_n] = addra;
        wr_data[wr_n] = dina;
      end
      wr_n = wr_n + 1;
    end
  end

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_last = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Offer one pixel (optionally after an idle gap cycle) and return #1 after its accept edge.
  task automatic send(input logic pix, input logic last, input logic gap);
    int t;
    t = 0;
    if (gap) begin
      s_valid = 1'b0; s_pixel = ~pix; s_last = 1'b1;
      @(posedge clk); #1;
    end
    s_valid = 1'b1; s_pixel = pix; s_last = last;
    while (!s_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 50) begin
      checks++; errors++;
      $display("FAIL accept_timeout: s_ready=%0b required 1", s_ready);
    end
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({wea, addra, dina, s_ready, busy, done, words_written} !== 28'd0) begin
      errors++;
      $display("FAIL reset_outputs: wea=%0b addra=%0h dina=%0h s_ready=%0b busy=%0b done=%0b ww=%0d required all 0",
               wea, addra, dina, s_ready, busy, done, words_written);
    end
  endtask

  task automatic test_pattern(input logic gap);
    int base;
    do_reset();
    base = wr_n;
    do_start();
    for (int i = 0; i < 16; i++) send(((i % 2) == 0) ? 1'b1 : 1'b0, 1'b0, gap);
    checks++;
    if ({wea, addra, dina} !== {1'b1, 4'h0, 16'hAAAA}) begin
      errors++;
      $display("FAIL pattern_write gap=%0b: wea=%0b addra=%0h dina=%0h required 1/0/aaaa", gap, wea, addra, dina);
    end
    checks++;
    if ({words_written, busy, done} !== {5'd1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL pattern_status gap=%0b: ww=%0d busy=%0b done=%0b required 1/1/0", gap, words_written, busy, done);
    end
    @(posedge clk); #1;
    checks++;
    if (wea !== 1'b0 || wr_n - base != 1) begin
      errors++;
      $display("FAIL pattern_pulse gap=%0b: wea=%0b writes=%0d required 0/1", gap, wea, wr_n - base);
    end
  endtask

  task automatic test_start_in_fill();
    // Continues from test_pattern: pointer at 1, one word written.
    do_start();
    for (int i = 0; i < 16; i++) send(1'b0, 1'b0, 1'b0);
    checks++;
    if ({wea, addra, dina, words_written} !== {1'b1, 4'h1, 16'h0000, 5'd2}) begin
      errors++;
      $display("FAIL start_in_fill: wea=%0b addra=%0h dina=%0h ww=%0d required 1/1/0000/2", wea, addra, dina, words_written);
    end
  endtask

  task automatic test_full(input logic last_at_end);
    int base;
    int bad;
    do_reset();
    base = wr_n;
    bad = 0;
    do_start();
    for (int i = 0; i < 256; i++) send(1'b1, (last_at_end && i == 255) ? 1'b1 : 1'b0, 1'b0);
    checks++;
    if ({wea, addra, s_ready, done, busy, words_written} !== {1'b1, 4'hF, 1'b0, 1'b1, 1'b0, 5'd16}) begin
      errors++;
      $display("FAIL full_end last=%0b: wea=%0b addra=%0h s_ready=%0b done=%0b busy=%0b ww=%0d required 1/f/0/1/0/16",
               last_at_end, wea, addra, s_ready, done, busy, words_written);
    end
    s_valid = 1'b1; s_pixel = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    s_valid = 1'b0;
    checks++;
    if (wr_n - base != 16 || done !== 1'b1 || words_written !== 5'd16) begin
      errors++;
      $display("FAIL full_count last=%0b: writes=%0d done=%0b ww=%0d required 16/1/16", last_at_end, wr_n - base, done, words_written);
    end
    for (int i = 0; i < 16; i++) begin
      if (wr_addr[base+i] !== 4'(i) || wr_data[base+i] !== 16'hFFFF) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL full_data last=%0b: %0d bad writes, required 0 (addr 0..15, data ffff)", last_at_end, bad);
    end
  endtask

  task automatic test_last_and_restart();
    int base;
    do_reset();
    base = wr_n;
    do_start();
    for (int i = 0; i < 20; i++) send(1'b1, (i == 19) ? 1'b1 : 1'b0, 1'b0);
    @(posedge clk); #1;
    checks++;
    if (wr_n - base != 2 || wr_addr[base] !== 4'h0 || wr_data[base] !== 16'hFFFF ||
        wr_addr[base+1] !== 4'h1 || wr_data[base+1] !== 16'hF000) begin
      errors++;
      $display("FAIL last_writes: n=%0d w0=%0h@%0h w1=%0h@%0h required 2 ffff@0 f000@1",
               wr_n - base, wr_data[base], wr_addr[base], wr_data[base+1], wr_addr[base+1]);
    end
    checks++;
    if ({done, busy, s_ready, words_written} !== {1'b1, 1'b0, 1'b0, 5'd2}) begin
      errors++;
      $display("FAIL last_status: done=%0b busy=%0b s_ready=%0b ww=%0d required 1/0/0/2", done, busy, s_ready, words_written);
    end
    do_start();
    checks++;
    if ({done, busy, words_written} !== {1'b0, 1'b1, 5'd0}) begin
      errors++;
      $display("FAIL restart_status: done=%0b busy=%0b ww=%0d required 0/1/0", done, busy, words_written);
    end
    for (int i = 0; i < 16; i++) send(((i % 4) == 0) ? 1'b1 : 1'b0, 1'b0, 1'b0);
    checks++;
    if ({wea, addra, dina} !== {1'b1, 4'h0, 16'h8888}) begin
      errors++;
      $display("FAIL restart_write: wea=%0b addra=%0h dina=%0h required 1/0/8888", wea, addra, dina);
    end
  endtask

  task automatic test_reset_mid_fill();
    int base;
    do_reset();
    do_start();
    for (int i = 0; i < 10; i++) send(1'b1, 1'b0, 1'b0);
    base = wr_n;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({wea, addra, dina, s_ready, busy, done, words_written} !== 28'd0) begin
      errors++;
      $display("FAIL async_reset: wea=%0b addra=%0h dina=%0h s_ready=%0b busy=%0b done=%0b ww=%0d required all 0",
               wea, addra, dina, s_ready, busy, done, words_written);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (wr_n != base || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_discard: writes=%0d busy=%0b required 0/0", wr_n - base, busy);
    end
    do_start();
    for (int i = 0; i < 16; i++) send(1'b1, 1'b0, 1'b0);
    checks++;
    if ({wea, addra, dina, words_written} !== {1'b1, 4'h0, 16'hFFFF, 5'd1}) begin
      errors++;
      $display("FAIL reset_refill: wea=%0b addra=%0h dina=%0h ww=%0d required 1/0/ffff/1", wea, addra, dina, words_written);
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_pattern(1'b0);
    test_start_in_fill();
    test_pattern(1'b1);
    test_full(1'b0);
    test_full(1'b1);
    test_last_and_restart();
    test_reset_mid_fill();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/image_mem_writer.md
IMAGE_MEM_WRITER -- requirements
Module: image_mem_writer

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 4, the memory address width; last address LAST_ADDR = 2^ADDR_WIDTH-1.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 16, the memory word width.
REQ-003 The block SHALL have parameter PIX_WIDTH, default 1, the pixel width; PPW = DATA_WIDTH/PIX_WIDTH pixels per word, integer by construction.
REQ-004 The block SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 The block SHALL have port start  input  1  one-cycle request to begin a new image fill.
REQ-007 The block SHALL have port s_valid  input  1  pixel valid.
REQ-008 The block SHALL have port s_ready  output  1  block accepts a pixel this cycle.
REQ-009 The block SHALL have port s_pixel  input  PIX_WIDTH  pixel value.
REQ-010 The block SHALL have port s_last  input  1  final pixel of the image, qualified by s_valid.
REQ-011 The block SHALL have port wea  output  1  memory write enable.
REQ-012 The block SHALL have port addra  output  ADDR_WIDTH  memory write address.
REQ-013 The block SHALL have port dina  output  DATA_WIDTH  memory write data.
REQ-014 The block SHALL have port busy  output  1  high in FILL state.
REQ-015 The block SHALL have port done  output  1  high in DONE state.
REQ-016 The block SHALL have port words_written  output  ADDR_WIDTH+1  count of words written since last start.

Function
REQ-017 The FSM SHALL have states IDLE, FILL, DONE; s_ready = (state == FILL).
REQ-018 IDLE/DONE: start SHALL move to FILL next cycle, clearing write pointer to 0, pack count to 0, words_written to 0, and done.
REQ-019 FILL: start SHALL be ignored.
REQ-020 A pixel SHALL be accepted when s_valid && s_ready; pixels are packed MSB-first: first pixel of a word in bits [DATA_WIDTH-1 -: PIX_WIDTH].
REQ-021 On acceptance of the PPW-th pixel of a word, or of any pixel with s_last=1, the block SHALL in the next cycle drive wea=1 for exactly one cycle with addra = write pointer and dina = packed word, unfilled low bits zero.
REQ-022 All of wea, addra, dina SHALL be registered; latency from final accepted pixel of a word to wea = 1 cycle.
REQ-023 Throughput SHALL be one pixel per cycle with no bubbles; the pack register is freed on the completing accept so the next pixel is accepted in the following cycle while the write is issued.
REQ-024 Each write SHALL increment the write pointer and words_written by 1.
REQ-025 After the write to LAST_ADDR the FSM SHALL enter DONE; the pointer SHALL NOT wrap and no further writes occur.
REQ-026 After the write triggered by s_last the FSM SHALL enter DONE, even if below LAST_ADDR.
REQ-027 s_last on the pixel that completes the word at LAST_ADDR SHALL produce one write only.
REQ-028 s_ready SHALL drop in the cycle after the completing accept that leads to DONE; no pixel is accepted after it.
REQ-029 wea SHALL be 0 whenever no write is issued; addra/dina SHALL hold their last values when wea=0.
REQ-030 DONE SHALL persist, done=1, until start.

Reset
REQ-031 rst SHALL immediately force state IDLE, wea=0, addra=0, dina=0, s_ready=0, busy=0, done=0, words_written=0, pack count 0.
REQ-032 rst during FILL SHALL discard the partial word and issue no write for it; a following start restarts at address 0.

Verification
REQ-033 start, 16 pixels 1,0,1,0,... -> one wea pulse, addra=0, dina=16'hAAAA, one cycle after 16th accept; words_written=1; busy=1.
REQ-034 start, 256 pixels all 1, s_valid continuous -> 16 writes addra 0..15, dina 16'hFFFF, done=1, s_ready=0, words_written=16, no 17th write.
REQ-035 start, 20 pixels all 1, s_last on 20th -> writes addr0=16'hFFFF, addr1=16'hF000, then done=1, words_written=2.
REQ-036 Scenario REQ-033 with s_valid toggling every cycle -> identical writes and values, wea still one cycle.
REQ-037 rst after 10 accepted pixels -> all outputs zero asynchronously, no wea; new start + 16 pixels of 1 -> write addr0=16'hFFFF.
REQ-038 start during FILL -> no effect on pointer/count; start in DONE -> done=0, busy=1 next cycle, next write at addra=0.
